// File: rtl/trisc_pkg.sv
// trisc_pkg: shared widths, memory depth and arbiter mode encoding for the TRISC memory arbiter.
package trisc_pkg;
  localparam int TRISC_AW = 4;
  localparam int TRISC_DW = 8;
  localparam int TRISC_DEPTH = 1 << TRISC_AW;
  localparam int WAIT_W = 4;
  typedef enum logic {
    MODE_CPU_PRI = 1'b0,
    MODE_PNL_PRI = 1'b1
  } mode_t;
endpackage

// File: rtl/trisc_starve_counter.sv
// trisc_starve_counter: counts panel cycles lost to the CPU and forces a panel grant at MAX_WAIT.
module trisc_starve_counter
  import trisc_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_pri,
  input  logic              halted,
  input  logic              pnl_req,
  input  logic              pnl_gnt,
  output logic [WAIT_W-1:0] cnt,
  output logic              force_pnl
);
  localparam logic [WAIT_W-1:0] MAX = WAIT_W'(MAX_WAIT);
  assign force_pnl = cpu_pri && cnt == MAX;
  // halted in CPU_PRI means the mode flips next cycle, so the count is dropped on entry
  always_ff @(posedge clk)
    if (!rst_n || !cpu_pri || halted || !pnl_req || pnl_gnt) cnt <= '0;
    else if (cnt != MAX) cnt <= cnt + 1'b1;
endmodule

// File: rtl/trisc_mem_arbiter.sv
// trisc_mem_arbiter: shares the single-port TRISC RAM between the CPU datapath and the front panel.
module trisc_mem_arbiter
  import trisc_pkg::*;
#(
  parameter int AW = TRISC_AW,
  parameter int DW = TRISC_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          SysClock,
  input  logic          ResetN,
  input  logic          Halted,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuGnt,
  output logic          CpuRValid,
  output logic [DW-1:0] CpuRData,
  input  logic          PnlReq,
  input  logic          PnlWe,
  input  logic [AW-1:0] PnlAddr,
  input  logic [DW-1:0] PnlWData,
  output logic          PnlGnt,
  output logic          PnlRValid,
  output logic [DW-1:0] PnlRData,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData
);
  mode_t mode, mode_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic force_pnl, cpu_win, pnl_win, cpu_rv_q, pnl_rv_q;
  trisc_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(SysClock),
    .rst_n(ResetN),
    .cpu_pri(mode == MODE_CPU_PRI),
    .halted(Halted),
    .pnl_req(PnlReq),
    .pnl_gnt(PnlGnt),
    .cnt(wait_cnt),
    .force_pnl(force_pnl)
  );
  always_ff @(posedge SysClock)
    if (!ResetN) mode <= MODE_CPU_PRI;
    else mode <= mode_next;
  always_comb begin
    mode_next = Halted ? MODE_PNL_PRI : MODE_CPU_PRI;
    pnl_win = ResetN && PnlReq && (mode == MODE_PNL_PRI || force_pnl || !CpuReq);
    cpu_win = ResetN && CpuReq && !pnl_win;
  end
  assign CpuGnt = cpu_win;
  assign PnlGnt = pnl_win;
  assign MemEn = cpu_win || pnl_win;
  assign MemWe = pnl_win ? PnlWe : cpu_win && CpuWe;
  assign MemAddr = pnl_win ? PnlAddr : cpu_win ? CpuAddr : '0;
  assign MemWData = pnl_win ? PnlWData : cpu_win ? CpuWData : '0;
  always_ff @(posedge SysClock) begin
    cpu_rv_q <= ResetN && cpu_win && !CpuWe;
    pnl_rv_q <= ResetN && pnl_win && !PnlWe;
  end
  // gating with ResetN keeps a read issued just before reset from surfacing during it
  assign CpuRValid = cpu_rv_q && ResetN;
  assign PnlRValid = pnl_rv_q && ResetN;
  assign CpuRData = CpuRValid ? MemRData : '0;
  assign PnlRData = PnlRValid ? MemRData : '0;
endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// tb_trisc_mem_arbiter: directed vector table, reset-mid-read sequence and randomized model check.
module tb_trisc_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MW = 4;
  logic SysClock = 0, ResetN = 0, Halted = 0;
  logic CpuReq = 0, CpuWe = 0, PnlReq = 0, PnlWe = 0;
  logic [AW-1:0] CpuAddr = '0, PnlAddr = '0, MemAddr;
  logic [DW-1:0] CpuWData = '0, PnlWData = '0, MemWData, CpuRData, PnlRData;
  logic [DW-1:0] MemRData = '0;
  logic CpuGnt, PnlGnt, CpuRValid, PnlRValid, MemEn, MemWe;
  logic [DW-1:0] ram [16];
  int tests = 0, fails = 0;

  trisc_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .SysClock(SysClock), .ResetN(ResetN), .Halted(Halted),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuRValid(CpuRValid), .CpuRData(CpuRData),
    .PnlReq(PnlReq), .PnlWe(PnlWe), .PnlAddr(PnlAddr), .PnlWData(PnlWData),
    .PnlGnt(PnlGnt), .PnlRValid(PnlRValid), .PnlRData(PnlRData),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData)
  );

  always #5 SysClock = ~SysClock;

  always @(posedge SysClock)
    if (MemEn) begin
      if (MemWe) ram[MemAddr] <= MemWData;
      else MemRData <= ram[MemAddr];
    end

  typedef struct {
    logic rst, h, cr, cw, pr, pw;
    logic [3:0] ca, pa;
    logic [7:0] cd, pd;
    logic [33:0] exp;
    int w;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [33:0] pack(logic cg, pg, en, we, logic [3:0] a, logic [7:0] wd,
                                       logic crv, logic [7:0] crd, logic prv, logic [7:0] prd);
    return {cg, pg, en, we, a, wd, crv, crd, prv, prd};
  endfunction

  function automatic logic [33:0] outs();
    return pack(CpuGnt, PnlGnt, MemEn, MemWe, MemAddr, MemWData, CpuRValid, CpuRData, PnlRValid, PnlRData);
  endfunction

  function automatic vec_t mk(int rst, h, cr, cw, ca, cd, pr, pw, pa, pd,
                              int cg, pg, we, ma, mwd, crv, crd, prv, prd, w);
    vec_t x;
    x.rst = 1'(rst); x.h = 1'(h);
    x.cr = 1'(cr); x.cw = 1'(cw); x.ca = 4'(ca); x.cd = 8'(cd);
    x.pr = 1'(pr); x.pw = 1'(pw); x.pa = 4'(pa); x.pd = 8'(pd);
    x.exp = pack(1'(cg), 1'(pg), 1'(cg | pg), 1'(we), 4'(ma), 8'(mwd), 1'(crv), 8'(crd), 1'(prv), 8'(prd));
    x.w = w;
    return x;
  endfunction

  task automatic drive(vec_t x);
    ResetN = x.rst; Halted = x.h;
    CpuReq = x.cr; CpuWe = x.cw; CpuAddr = x.ca; CpuWData = x.cd;
    PnlReq = x.pr; PnlWe = x.pw; PnlAddr = x.pa; PnlWData = x.pd;
  endtask

  task automatic check(string name, logic [33:0] act, logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge SysClock);
    #1;
  endtask

  logic [DW-1:0] mm [16];
  bit m_pnl, m_rvc, m_rvp, cg, pg, frc;
  logic [DW-1:0] m_rdc, m_rdp;
  int m_wait;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
    ram[3] = 8'hA5;
    // reset, CPU read, starvation, halt handover, back-to-back panel, readback
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0, 1,0,3,0, 1,1,5,8'h55, 0,0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0, 1,0,3,0, 1,1,5,8'h55, 1,0,0,3,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,8'hA5,0,0, 1));
    vecs.push_back(mk(1,0, 1,0,3,0, 1,0,1,0, 1,0,0,3,0, 0,0,0,0, 0));
    for (int i = 1; i < 4; i++) vecs.push_back(mk(1,0, 1,0,3,0, 1,0,1,0, 1,0,0,3,0, 1,8'hA5,0,0, i));
    vecs.push_back(mk(1,0, 1,0,3,0, 1,0,1,0, 0,1,0,1,0, 1,8'hA5,0,0, 4));
    vecs.push_back(mk(1,0, 1,0,3,0, 1,0,1,0, 1,0,0,3,0, 0,0,1,8'h11, 0));
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,8'hA5,0,0, 1));
    vecs.push_back(mk(1,1, 1,0,3,0, 1,1,15,8'h3C, 1,0,0,3,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1, 1,0,3,0, 1,1,15,8'h3C, 0,1,1,15,8'h3C, 1,8'hA5,0,0, 0));
    vecs.push_back(mk(1,1, 1,0,3,0, 1,0,1,0, 0,1,0,1,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1, 1,0,3,0, 1,1,2,8'h77, 0,1,1,2,8'h77, 0,0,1,8'h11, 0));
    vecs.push_back(mk(1,1, 1,0,3,0, 0,0,0,0, 1,0,0,3,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,1, 1,0,15,0, 0,0,0,0, 1,0,0,15,0, 1,8'hA5,0,0, 0));
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,8'h3C,0,0, 0));
    vecs.push_back(mk(1,0, 1,0,2,0, 0,0,0,0, 1,0,0,2,0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,8'h77,0,0, 0));
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge SysClock);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      check($sformatf("wait%0d", i), 34'(dut.wait_cnt), 34'(vecs[i].w));
      next_cycle();
    end

    // reset asserted in the cycle after a CPU read grant
    drive(mk(1,0, 1,0,3,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
    @(negedge SysClock);
    check("midrd_gnt", outs(), pack(1,0,1,0,4'd3,8'd0, 0,8'd0,0,8'd0));
    next_cycle();
    drive(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0));
    @(negedge SysClock);
    check("midrd_rst", outs(), 34'd0);
    next_cycle();
    ResetN = 1;
    @(negedge SysClock);
    check("midrd_rel", outs(), 34'd0);
    next_cycle();

    // randomized traffic against the reference model
    foreach (ram[i]) mm[i] = ram[i];
    m_pnl = 0; m_wait = 0; m_rvc = 0; m_rvp = 0; m_rdc = '0; m_rdp = '0;
    cg = 0; pg = 0;
    for (int c = 0; c < 800; c++) begin
      ResetN = (c >= 2) && ($urandom_range(99) != 0);
      if ($urandom_range(24) == 0) Halted = ~Halted;
      if (!CpuReq || cg) begin
        CpuReq = $urandom_range(3) != 0; CpuWe = $urandom_range(3) == 0;
        CpuAddr = 4'($urandom); CpuWData = 8'($urandom);
      end
      if (!PnlReq || pg) begin
        PnlReq = $urandom_range(2) != 0; PnlWe = $urandom_range(1) == 0;
        PnlAddr = 4'($urandom); PnlWData = 8'($urandom);
      end
      frc = !m_pnl && m_wait == MW;
      pg = ResetN && PnlReq && (m_pnl || frc || !CpuReq);
      cg = ResetN && CpuReq && !pg;
      @(negedge SysClock);
      check($sformatf("rnd%0d", c), outs(),
            pack(cg, pg, cg || pg, pg ? PnlWe : cg && CpuWe,
                 pg ? PnlAddr : cg ? CpuAddr : 4'd0, pg ? PnlWData : cg ? CpuWData : 8'd0,
                 ResetN && m_rvc, (ResetN && m_rvc) ? m_rdc : 8'd0,
                 ResetN && m_rvp, (ResetN && m_rvp) ? m_rdp : 8'd0));
      check($sformatf("rndwait%0d", c), 34'(dut.wait_cnt), 34'(m_wait));
      if (!ResetN) begin
        m_pnl = 0; m_wait = 0; m_rvc = 0; m_rvp = 0;
      end else begin
        m_rvc = cg && !CpuWe; m_rdc = mm[CpuAddr];
        m_rvp = pg && !PnlWe; m_rdp = mm[PnlAddr];
        if (cg && CpuWe) mm[CpuAddr] = CpuWData;
        if (pg && PnlWe) mm[PnlAddr] = PnlWData;
        m_wait = (!m_pnl && !Halted && PnlReq && !pg) ? (m_wait < MW ? m_wait + 1 : MW) : 0;
        m_pnl = Halted;
      end
      next_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trisc_mem_arbiter.md
Name: trisc_mem_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the TRISC control unit datapath (instruction fetch, LDA/STA) and the front-panel loader (switch-entered program words).
- Sits between both requesters and the synchronous RAM.
- The CPU has priority while running. The panel has priority once the CPU executes HLT.
- A starvation counter guarantees the panel a slot during run mode.

Parameters:
- AW, 4, address width (16-word TRISC memory)
- DW, 8, data word width
- MAX_WAIT, 4, panel wait cycles in CPU-priority mode before forced panel grant (range 1..15)

Ports:
- SysClock  in  1  system clock; all state updates on rising edge
- ResetN  in  1  synchronous active-low reset
- Halted  in  1  high while the control unit sits in HLT
- CpuReq  in  1  CPU access request, held until CpuGnt
- CpuWe  in  1  1 = write, 0 = read
- CpuAddr  in  AW  CPU address
- CpuWData  in  DW  CPU write data
- CpuGnt  out  1  CPU access issued this cycle
- CpuRValid  out  1  CPU read data valid
- CpuRData  out  DW  CPU read data
- PnlReq, PnlWe, PnlAddr, PnlWData  in  1/1/AW/DW  panel request fields, same rules as CPU
- PnlGnt, PnlRValid  out  1  panel grant / read valid
- PnlRData  out  DW  panel read data
- MemEn, MemWe  out  1  RAM enable / write enable
- MemAddr  out  AW  RAM address
- MemWData  out  DW  RAM write data
- MemRData  in  DW  RAM read data, valid one cycle after a read-enable

Behaviour:
- Reset (ResetN=0 at edge):
  - Mode := CPU_PRI, WaitCnt := 0, CpuRValid := 0, PnlRValid := 0.
  - While ResetN=0, CpuGnt, PnlGnt, MemEn and MemWe are forced to 0.
- Transactions are single-cycle with at most one grant per cycle.
  - Grant is combinational from the current requests and registered Mode/WaitCnt.
  - In a grant cycle, Mem* carry the winner's fields and MemEn=1. MemWe equals the winner's We.
  - With no grant: MemEn=0, MemWe=0, MemAddr/MemWData=0.
- Requester rule: Req/We/Addr/WData are held stable until the Gnt cycle. Req may drop or change in the cycle after Gnt.
- Read return: a granted read in cycle t gives RValid=1 in cycle t+1 only, with RData=MemRData. RData is 0 whenever RValid=0. Write grants produce no RValid.
- Mode FSM (registered):
  - CPU_PRI -> PNL_PRI when Halted=1.
  - PNL_PRI -> CPU_PRI when Halted=0.
  - Takes effect the cycle after Halted changes. No transaction is ever split, because all are single-cycle.
- CPU_PRI arbitration:
  - PnlReq and WaitCnt==MAX_WAIT: panel wins.
  - Else CpuReq: CPU wins.
  - Else PnlReq: panel wins.
- PNL_PRI arbitration: PnlReq wins, else CpuReq.
- WaitCnt (4-bit, saturating at MAX_WAIT):
  - Increments each cycle in CPU_PRI with PnlReq=1 and PnlGnt=0.
  - Clears to 0 on PnlGnt, on PnlReq=0, or on entry to PNL_PRI.
- Simultaneous events:
  - Read return in t+1 coincides with a new grant in t+1: both occur; the pipeline is fully overlapped.
  - A Halted change in the same cycle as a forced panel grant: the grant completes, then WaitCnt clears.
- Reset mid-read: a pending RValid is suppressed (cleared to 0) and no stale data is returned.

Decomposition:
- Shared package trisc_pkg: mode encoding (MODE_CPU_PRI=1'b0, MODE_PNL_PRI=1'b1), default AW/DW widths, and the TRISC memory depth constant.
- One natural sub-module: trisc_starve_counter, holding the WaitCnt increment/clear/saturate logic and the "force" flag output.
- Grant mux and FSM stay in the top.

Test Plan:
- Reset: hold ResetN=0 for 3 cycles with both Req=1 -> no Gnt, MemEn=0. On release the CPU is granted first cycle.
- CPU read: CpuReq=1, CpuWe=0, CpuAddr=4'h3, RAM[3]=8'hA5 -> CpuGnt in t, CpuRValid=1 and CpuRData=8'hA5 in t+1, PnlRValid=0.
- Starvation, MAX_WAIT=4, Halted=0: CpuReq and PnlReq held continuously from t0.
  - CPU is granted t0–t3; panel is granted at t4, then CPU again at t5.
  - Check WaitCnt goes 0,1,2,3,4,0.
- Halt handover: Halted rises at t0 with both requesting -> CPU granted t0, panel granted from t1 onward. A panel write of 8'h3C at 4'hF is visible via a later CPU read.
- Back-to-back: panel reads 4'h1 (t0) and writes 4'h2=8'h77 (t1) in PNL_PRI -> PnlRValid only at t1, MemWe=1 only at t1.
- Reset mid-read: ResetN=0 in the cycle after a CPU read grant -> CpuRValid stays 0.
